// File: rtl/link_pkg.sv
// Shared link-layer definitions for the keep-alive transmit/receive pair:
// sync header codes, the default keep-alive type byte and the state/class enums.
package link_pkg;

  localparam logic [1:0] SYNC_DATA       = 2'b01;
  localparam logic [1:0] SYNC_CTRL       = 2'b10;
  localparam logic [7:0] KA_TYPE_DEFAULT = 8'h1E;

  typedef enum logic [1:0] {
    DOWN,
    LOCKING,
    UP
  } link_state_t;

  typedef enum logic [1:0] {
    DATA,
    KA,
    CTRL_OTHER,
    BAD
  } word_class_t;

endpackage

// File: rtl/keep_alive_in_if.sv
// Word stream around the keep-alive receiver: aligned rx words in, payload words out.
interface keep_alive_in_if #(
  parameter int W = 128
);

  logic [0:W-1] idata;
  logic [0:5]   iheader;
  logic         ivalid;
  logic [0:W-1] odata;
  logic         ovalid;

  modport master (
    output idata, iheader, ivalid,
    input  odata, ovalid
  );

  modport slave (
    input  idata, iheader, ivalid,
    output odata, ovalid
  );

endinterface

// File: rtl/word_classify.sv
// Combinational decode of a word's sync bits and control type byte into a word class.
module word_classify
  import link_pkg::*;
#(
  parameter logic [7:0] KA_TYPE = KA_TYPE_DEFAULT
) (
  input  logic [0:1]  sync,
  input  logic [0:7]  type_byte,
  output word_class_t cls
);

  always_comb begin
    cls = BAD;
    if (sync == SYNC_DATA) begin
      cls = DATA;
    end else if (sync == SYNC_CTRL) begin
      cls = (type_byte == KA_TYPE) ? KA : CTRL_OTHER;
    end
  end

endmodule

// File: rtl/keep_alive_in.sv
// Lane receive filter: strips keep-alives, forwards data while the link is up,
// and runs the DOWN/LOCKING/UP link state machine with watchdog and bad-burst drop.
module keep_alive_in
  import link_pkg::*;
#(
  parameter int         w          = 128,
  parameter int         LOCK_COUNT = 64,
  parameter int         TIMEOUT    = 1024,
  parameter int         BAD_LIMIT  = 16,
  parameter logic [7:0] KA_TYPE    = KA_TYPE_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  keep_alive_in_if.slave       rx,
  output logic                 link_up,
  output logic                 ka_seen,
  output logic [15:0]          err_count
);

  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BAD_LIMIT + 1);

  link_state_t   state_q, state_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [TW-1:0] wd_cnt_q, wd_cnt_d;
  logic [BW-1:0] bad_cnt_q, bad_cnt_d;
  logic [15:0]   err_count_q, err_count_d;
  logic [0:w-1]  odata_q, odata_d;
  logic          ovalid_q, ovalid_d;
  logic          ka_seen_q, ka_seen_d;
  logic          wd_trip, bad_trip;
  word_class_t   cls;

  // Only the two sync bits of the gearbox header carry meaning here.
  logic unused_hdr;
  assign unused_hdr = ^rx.iheader[0:3];

  word_classify #(
    .KA_TYPE (KA_TYPE)
  ) u_classify (
    .sync      (rx.iheader[4:5]),
    .type_byte (rx.idata[0:7]),
    .cls       (cls)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= DOWN;
      lock_cnt_q  <= '0;
      wd_cnt_q    <= '0;
      bad_cnt_q   <= '0;
      err_count_q <= '0;
      odata_q     <= '0;
      ovalid_q    <= 1'b0;
      ka_seen_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      err_count_q <= err_count_d;
      odata_q     <= odata_d;
      ovalid_q    <= ovalid_d;
      ka_seen_q   <= ka_seen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    err_count_d = err_count_q;
    odata_d     = odata_q;
    ovalid_d    = 1'b0;
    ka_seen_d   = 1'b0;
    wd_trip     = 1'b0;
    bad_trip    = 1'b0;

    // Pause cycles from the gearbox leave every piece of state untouched.
    if (rx.ivalid) begin
      odata_d   = rx.idata;
      ka_seen_d = (cls == KA);
      if ((cls == BAD || cls == CTRL_OTHER) && err_count_q != 16'hFFFF) begin
        err_count_d = err_count_q + 16'd1;
      end

      case (state_q)
        DOWN: begin
          if (cls == KA) begin
            if (lock_cnt_q == LW'(LOCK_COUNT - 1)) begin
              state_d    = LOCKING;
              lock_cnt_d = '0;
            end else begin
              lock_cnt_d = lock_cnt_q + LW'(1);
            end
          end else begin
            lock_cnt_d = '0;
          end
        end

        LOCKING: begin
          if (cls == KA || cls == DATA) begin
            state_d  = UP;
            ovalid_d = (cls == DATA);
          end else begin
            state_d    = DOWN;
            lock_cnt_d = '0;
          end
        end

        UP: begin
          // A keep-alive landing on the would-be timeout cycle rescues the link.
          wd_trip  = (cls != KA) && (wd_cnt_q == TW'(TIMEOUT - 1));
          bad_trip = (cls == BAD) && (bad_cnt_q == BW'(BAD_LIMIT - 1));
          if (wd_trip || bad_trip) begin
            state_d    = DOWN;
            lock_cnt_d = '0;
            wd_cnt_d   = '0;
            bad_cnt_d  = '0;
          end else begin
            wd_cnt_d = (cls == KA) ? '0 : wd_cnt_q + TW'(1);
            if (cls == BAD) begin
              bad_cnt_d = bad_cnt_q + BW'(1);
            end else if (cls != CTRL_OTHER) begin
              bad_cnt_d = '0;
            end
            ovalid_d = (cls == DATA);
          end
        end

        default: begin
          state_d    = DOWN;
          lock_cnt_d = '0;
          wd_cnt_d   = '0;
          bad_cnt_d  = '0;
        end
      endcase
    end
  end

  assign rx.odata  = odata_q;
  assign rx.ovalid = ovalid_q;
  assign link_up   = (state_q == UP);
  assign ka_seen   = ka_seen_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_keep_alive_in.sv
// Directed bench for keep_alive_in: expected payload words go into a queue that a
// forked monitor drains on every ovalid; link/error/keep-alive state is checked inline.
module tb_keep_alive_in;
  import link_pkg::*;

  localparam int W = 128;
  localparam logic [0:W-1] KA_WORD   = {8'h1E, {(W-8){1'b0}}};
  localparam logic [0:W-1] CTRL_WORD = {8'h55, {(W-8){1'b0}}};

  logic        clock = 1'b0;
  logic        reset;
  logic        link_up;
  logic        ka_seen;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;
  int ka_cnt = 0;
  int ov_cnt = 0;
  int k0, o0;
  logic [0:W-1] exp_q[$];

  keep_alive_in_if #(.W(W)) rx ();

  keep_alive_in #(
    .w          (W),
    .LOCK_COUNT (64),
    .TIMEOUT    (1024),
    .BAD_LIMIT  (16),
    .KA_TYPE    (8'h1E)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .link_up   (link_up),
    .ka_seen   (ka_seen),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("check %s: got %0h", name, act);
    end
  endtask

  // Inputs change one time unit after the falling edge, so both the DUT sampling
  // edge and the monitor's falling-edge sample have already happened on return.
  task automatic drive(input logic [1:0] sync, input logic [0:W-1] d, input logic v);
    rx.iheader = {4'b0000, sync};
    rx.idata   = d;
    rx.ivalid  = v;
    @(negedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(2'b00, '0, 1'b0);
  endtask

  task automatic send_ka(input int n);
    repeat (n) drive(2'b10, KA_WORD, 1'b1);
  endtask

  task automatic send_data(input int v, input bit forwarded);
    if (forwarded) exp_q.push_back(W'(v));
    drive(2'b01, W'(v), 1'b1);
  endtask

  task automatic send_bad(input int n);
    for (int i = 0; i < n; i++) drive((i % 2 == 0) ? 2'b11 : 2'b00, W'(i), 1'b1);
  endtask

  task automatic monitor();
    logic [0:W-1] exp;
    forever begin
      @(negedge clock);
      if (rx.ovalid === 1'b1) begin
        check("ovalid_expected", 128'(rx.ovalid), 128'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          check("odata", rx.odata, exp);
        end
        ov_cnt++;
      end
      if (ka_seen === 1'b1) ka_cnt++;
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    reset     = 1'b1;
    rx.ivalid = 1'b0;
    rx.idata  = '0;
    rx.iheader = '0;
    fork
      monitor();
    join_none
    @(negedge clock);
    #1;
    idle(2);
    check("rst_link_up", link_up, 0);
    check("rst_ovalid", rx.ovalid, 0);
    check("rst_odata", rx.odata, 0);
    check("rst_ka_seen", ka_seen, 0);
    check("rst_err_count", err_count, 0);
    reset = 1'b0;

    // Lock: 64 keep-alives reach LOCKING, one more confirms UP.
    k0 = ka_cnt;
    send_ka(64);
    check("lock_pending", link_up, 0);
    check("lock_ka_pulses", ka_cnt - k0, 64);
    send_ka(1);
    check("lock_up", link_up, 1);
    check("lock_err", err_count, 0);

    // Lock interrupted by a bad header restarts the count.
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    send_ka(40);
    send_bad(1);
    send_ka(64);
    check("relock_pending", link_up, 0);
    send_ka(1);
    check("relock_up", link_up, 1);
    check("relock_err", err_count, 1);

    // Data pass-through with interleaved keep-alives and pause cycles.
    o0 = ov_cnt;
    send_data(1, 1);
    check("data_latency", rx.ovalid, 1);
    idle(1);
    check("data_gap_ovalid", rx.ovalid, 0);
    send_ka(1);
    check("ka_not_forwarded", rx.ovalid, 0);
    idle(2);
    send_data(2, 1);
    send_ka(1);
    send_data(3, 1);
    idle(1);
    check("data_count", ov_cnt - o0, 3);
    check("data_queue_drained", exp_q.size(), 0);
    drive(2'b10, CTRL_WORD, 1'b1);
    check("ctrl_err", err_count, 2);
    check("ctrl_link_up", link_up, 1);

    // Watchdog: 1024 valid cycles with no keep-alive drop the link.
    send_ka(1);
    for (int i = 1; i <= 1023; i++) send_data(i, 1);
    check("wd_before_trip", link_up, 1);
    send_data(1024, 0);
    check("wd_tripped", link_up, 0);
    check("wd_drop_not_fwd", rx.ovalid, 0);

    // Keep-alive at valid cycle 1023, then at exactly cycle 1024.
    send_ka(65);
    check("wd2_up", link_up, 1);
    for (int i = 1; i <= 1022; i++) send_data(i, 1);
    send_ka(1);
    for (int i = 0; i < 5; i++) send_data(i + 100, 1);
    check("wd_ka_1023", link_up, 1);
    send_ka(1);
    for (int i = 1; i <= 1023; i++) send_data(i, 1);
    send_ka(1);
    send_data(7, 1);
    check("wd_ka_1024", link_up, 1);

    // Bad burst: 15 bad, data, 15 bad survive; 16 consecutive drop.
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    send_ka(65);
    send_bad(15);
    send_data(9, 1);
    send_bad(15);
    check("bad_survive", link_up, 1);
    check("bad_err30", err_count, 30);
    send_bad(16);
    check("bad_drop", link_up, 0);
    check("bad_err46", err_count, 46);

    // Saturation, then a reset pulse while the link is up.
    send_bad(70000);
    check("sat_err", err_count, 16'hFFFF);
    send_ka(65);
    check("sat_up", link_up, 1);
    check("sat_hold", err_count, 16'hFFFF);
    reset = 1'b1;
    send_data(77, 0);
    check("mid_rst_link_up", link_up, 0);
    check("mid_rst_ovalid", rx.ovalid, 0);
    check("mid_rst_odata", rx.odata, 0);
    check("mid_rst_ka_seen", ka_seen, 0);
    check("mid_rst_err", err_count, 0);
    reset = 1'b0;
    k0 = ka_cnt;
    send_ka(64);
    check("post_rst_down", link_up, 0);
    send_ka(1);
    check("post_rst_up", link_up, 1);
    check("post_rst_ka_pulses", ka_cnt - k0, 65);

    idle(2);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
